// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_if
// Purpose  : Byte-wide shared memory bus between the MEM stage and arbiter.
// Revision : 1.0
// ============================================================================
interface mem_access_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req_o;
    logic              mem_gnt_i;
    logic [ADDR_W-1:0] mem_a_o;
    logic              mem_wr_o;
    logic [7:0]        mem_dout_o;
    logic [7:0]        mem_din_i;

    modport master (
        output mem_req_o, mem_a_o, mem_wr_o, mem_dout_o,
        input  mem_gnt_i, mem_din_i
    );

    modport slave (
        input  mem_req_o, mem_a_o, mem_wr_o, mem_dout_o,
        output mem_gnt_i, mem_din_i
    );
endinterface
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Purpose  : MEM-stage byte-serial load/store engine with pipeline stall.
//            Optional misalignment trap: define MEM_MISALIGN_CHK_EN.
// Revision : 1.0
// ============================================================================
module mem_access #(
    parameter int         ADDR_W       = 32,
    parameter logic [6:0] LOAD_OPCODE  = 7'b0000011,
    parameter logic [6:0] STORE_OPCODE = 7'b0100011
) (
    input  wire               clk,
    input  wire               rst,
    input  wire               rdy,
    input  wire               valid_i,
    input  wire  [6:0]        opcode_i,
    input  wire  [2:0]        funct3_i,
    input  wire  [ADDR_W-1:0] mem_addr_i,
    input  wire  [31:0]       wdata_i,
    input  wire  [4:0]        wd_i,
    input  wire               wreg_i,
    output logic              valid_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              stall_req_o,
    mem_access_if.master      bus,
    output logic              err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         asm_q;
    logic [4:0]          wd_q;
    logic                wreg_q;
    logic [2:0]          f3_q;
    logic                ld_q, st_q, err_q;
    logic [1:0]          k_q;
    logic                pend_q;
    logic [1:0]          pend_k_q;

    logic                w_is_mem;
    logic                w_is_ld;
    logic                w_misalign;
    logic                w_accept;
    logic                w_issue;
    logic [1:0]          w_last_k;
    logic [31:0]         w_ld_ext;
    logic                w_req, w_wr;
    logic [ADDR_W-1:0]   w_addr;
    logic [7:0]          w_dout;

    assign w_is_ld  = (opcode_i == LOAD_OPCODE);
    assign w_is_mem = (w_is_ld || opcode_i == STORE_OPCODE) &&
                      (funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

`ifdef MEM_MISALIGN_CHK_EN
    assign w_misalign = (funct3_i[1:0] == 2'b01 && mem_addr_i[0]) ||
                        (funct3_i[1:0] == 2'b10 && mem_addr_i[1:0] != 2'b00);
    assign err_o      = (state_q == S_DONE) && err_q;
`else
    assign w_misalign = 1'b0;
    assign err_o      = 1'b0;
`endif

    assign w_accept = (state_q == S_IDLE) && valid_i && rdy;
    // A byte only counts as issued when the request was actually driven.
    assign w_issue  = (state_q == S_XFER) && bus.mem_gnt_i && rdy;
    assign w_last_k = f3_q[1] ? 2'd3 : (f3_q[0] ? 2'd1 : 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            asm_q    <= '0;
            wd_q     <= '0;
            wreg_q   <= 1'b0;
            f3_q     <= '0;
            ld_q     <= 1'b0;
            st_q     <= 1'b0;
            err_q    <= 1'b0;
            k_q      <= '0;
            pend_q   <= 1'b0;
            pend_k_q <= '0;
        end else if (rdy) begin
            if (w_accept) begin
                addr_q  <= mem_addr_i;
                wdata_q <= wdata_i;
                wd_q    <= wd_i;
                wreg_q  <= wreg_i;
                f3_q    <= funct3_i;
                ld_q    <= w_is_mem && !w_misalign && w_is_ld;
                st_q    <= w_is_mem && !w_misalign && !w_is_ld;
                err_q   <= w_is_mem && w_misalign;
                k_q     <= '0;
                asm_q   <= '0;
            end
            if (w_issue) begin
                k_q <= k_q + 2'd1;
            end
            // Read data returns one cycle after a granted issue.
            pend_q   <= w_issue && ld_q;
            pend_k_q <= k_q;
            if (pend_q) begin
                asm_q[{pend_k_q, 3'b000} +: 8] <= bus.mem_din_i;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        valid_o     = 1'b0;
        wd_o        = '0;
        wreg_o      = 1'b0;
        wdata_o     = '0;
        stall_req_o = 1'b0;
        w_req       = 1'b0;
        w_wr        = 1'b0;
        w_addr      = '0;
        w_dout      = '0;

        case (f3_q)
            3'b000:  w_ld_ext = {{24{asm_q[7]}}, asm_q[7:0]};
            3'b001:  w_ld_ext = {{16{asm_q[15]}}, asm_q[15:0]};
            3'b100:  w_ld_ext = {24'd0, asm_q[7:0]};
            3'b101:  w_ld_ext = {16'd0, asm_q[15:0]};
            default: w_ld_ext = asm_q;
        endcase

        case (state_q)
            S_IDLE: begin
                stall_req_o = valid_i && w_is_mem;
                if (w_accept) begin
                    state_d = (w_is_mem && !w_misalign) ? S_XFER : S_DONE;
                end
            end
            S_XFER: begin
                stall_req_o = 1'b1;
                w_req       = rdy;
                w_wr        = rdy && st_q;
                w_addr      = addr_q + ADDR_W'(k_q);
                w_dout      = wdata_q[{k_q, 3'b000} +: 8];
                if (w_issue && k_q == w_last_k) begin
                    state_d = ld_q ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                stall_req_o = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                valid_o = 1'b1;
                wd_o    = wd_q;
                wreg_o  = wreg_q && !st_q && !err_q;
                if (ld_q) begin
                    wdata_o = w_ld_ext;
                end else if (!st_q && !err_q) begin
                    wdata_o = wdata_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.mem_req_o  = w_req;
    assign bus.mem_wr_o   = w_wr;
    assign bus.mem_a_o    = w_addr;
    assign bus.mem_dout_o = w_dout;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Purpose  : Directed self-checking bench for mem_access with a byte memory.
// Revision : 1.0
// ============================================================================
module tb_mem_access;

    localparam logic [6:0] C_LOAD  = 7'b0000011;
    localparam logic [6:0] C_STORE = 7'b0100011;
    localparam logic [6:0] C_ALU   = 7'b0010011;

    logic        clk, rst, rdy, valid_i, wreg_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [31:0] mem_addr_i, wdata_i;
    logic [4:0]  wd_i;
    logic        valid_o, wreg_o, stall_req_o, err_o;
    logic [4:0]  wd_o;
    logic [31:0] wdata_o;

    mem_access_if #(.ADDR_W(32)) bus_if ();

    mem_access #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .valid_i     (valid_i),
        .opcode_i    (opcode_i),
        .funct3_i    (funct3_i),
        .mem_addr_i  (mem_addr_i),
        .wdata_i     (wdata_i),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .valid_o     (valid_o),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .stall_req_o (stall_req_o),
        .bus         (bus_if.master),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory behind the arbiter; read data appears the cycle after issue.
    logic [7:0] mem [4096];
    always @(posedge clk) begin
        if (rst) begin
            mem[12'h100] <= 8'h11; mem[12'h101] <= 8'h22;
            mem[12'h102] <= 8'h33; mem[12'h103] <= 8'h44;
            mem[12'h104] <= 8'h55; mem[12'h105] <= 8'h66;
            mem[12'h110] <= 8'h80;
            mem[12'h120] <= 8'h01; mem[12'h121] <= 8'h80;
            mem[12'hFFF] <= 8'hA5;
            mem[12'h000] <= 8'h01; mem[12'h001] <= 8'h02; mem[12'h002] <= 8'h03;
        end else if (bus_if.mem_req_o && bus_if.mem_gnt_i) begin
            if (bus_if.mem_wr_o) mem[bus_if.mem_a_o[11:0]] <= bus_if.mem_dout_o;
            else                 bus_if.mem_din_i <= mem[bus_if.mem_a_o[11:0]];
        end
    end

    int          n_cmp, n_fail;
    int          vcyc, vcnt;
    logic [31:0] vdata;
    logic [4:0]  vwd;
    logic        vwreg, verr;
    logic [15:0] stall_m, req_m, wr_m;
    logic [31:0] a_log [16];
    logic [7:0]  d_log [16];

    // Present one bundle in cycle 0 and log 16 cycles of DUT behaviour.
    task automatic run_op(input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input logic we,
                          input int nognt_c, input int rst_c, input int rdy_c);
        vcyc = -1; vcnt = 0; vdata = '0; vwd = '0; vwreg = 1'b0; verr = 1'b0;
        stall_m = '0; req_m = '0; wr_m = '0;
        opcode_i = op; funct3_i = f3; mem_addr_i = addr; wdata_i = wd;
        wd_i = rd; wreg_i = we;
        for (int c = 0; c < 16; c++) begin
            valid_i          = (c == 0);
            bus_if.mem_gnt_i = (c != nognt_c);
            rst              = (c == rst_c);
            rdy              = (c != rdy_c);
            #1;
            stall_m[c] = stall_req_o;
            req_m[c]   = bus_if.mem_req_o;
            wr_m[c]    = bus_if.mem_wr_o;
            a_log[c]   = bus_if.mem_a_o;
            d_log[c]   = bus_if.mem_dout_o;
            if (valid_o) begin
                vcnt++;
                if (vcyc < 0) begin
                    vcyc = c; vdata = wdata_o; vwd = wd_o; vwreg = wreg_o; verr = err_o;
                end
            end
            @(posedge clk); #1;
        end
        valid_i = 1'b0; rst = 1'b0; rdy = 1'b1; bus_if.mem_gnt_i = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; rdy = 1'b1; valid_i = 1'b0; bus_if.mem_gnt_i = 1'b1;
        opcode_i = '0; funct3_i = '0; mem_addr_i = '0; wdata_i = '0; wd_i = '0; wreg_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({valid_o, wreg_o, stall_req_o, err_o} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {valid_o, wreg_o, stall_req_o, err_o}); end
        n_cmp++; if ({wd_o, wdata_o} !== 37'd0) begin n_fail++; $display("FAIL reset_wb: got wd=%h data=%h want 0", wd_o, wdata_o); end
        n_cmp++; if ({bus_if.mem_req_o, bus_if.mem_wr_o, bus_if.mem_a_o, bus_if.mem_dout_o} !== 42'd0) begin n_fail++; $display("FAIL reset_bus: got req=%b wr=%b a=%h d=%h want 0", bus_if.mem_req_o, bus_if.mem_wr_o, bus_if.mem_a_o, bus_if.mem_dout_o); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lw;
        run_op(C_LOAD, 3'b010, 32'h100, 32'h0, 5'd5, 1'b1, -1, -1, -1);
        n_cmp++; if (vcyc !== 6) begin n_fail++; $display("FAIL lw_valid_cycle: got %0d want 6", vcyc); end
        n_cmp++; if (vcnt !== 1) begin n_fail++; $display("FAIL lw_valid_pulses: got %0d want 1", vcnt); end
        n_cmp++; if (vdata !== 32'h44332211) begin n_fail++; $display("FAIL lw_data: got %h want 44332211", vdata); end
        n_cmp++; if ({vwreg, vwd, verr} !== {1'b1, 5'd5, 1'b0}) begin n_fail++; $display("FAIL lw_wb: got wreg=%b wd=%0d err=%b want 1 5 0", vwreg, vwd, verr); end
        n_cmp++; if (stall_m !== 16'h003F) begin n_fail++; $display("FAIL lw_stall: got %h want 003f", stall_m); end
        n_cmp++; if (req_m !== 16'h001E || wr_m !== 16'h0) begin n_fail++; $display("FAIL lw_req: got req=%h wr=%h want 001e 0000", req_m, wr_m); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (a_log[i+1] !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL lw_addr%0d: got %h want %h", i, a_log[i+1], 32'h100 + 32'(i)); end
        end
    endtask

    task automatic test_narrow_loads;
        run_op(C_LOAD, 3'b000, 32'h110, 32'h0, 5'd6, 1'b1, -1, -1, -1);
        n_cmp++; if (vcyc !== 3) begin n_fail++; $display("FAIL lb_valid_cycle: got %0d want 3", vcyc); end
        n_cmp++; if (vdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_data: got %h want ffffff80", vdata); end
        run_op(C_LOAD, 3'b101, 32'h120, 32'h0, 5'd7, 1'b1, -1, -1, -1);
        n_cmp++; if (vcyc !== 4) begin n_fail++; $display("FAIL lhu_valid_cycle: got %0d want 4", vcyc); end
        n_cmp++; if (vdata !== 32'h00008001) begin n_fail++; $display("FAIL lhu_data: got %h want 00008001", vdata); end
    endtask

    task automatic test_store_half;
        run_op(C_STORE, 3'b001, 32'h200, 32'hABCD1234, 5'd9, 1'b1, -1, -1, -1);
        n_cmp++; if (wr_m !== 16'h0006) begin n_fail++; $display("FAIL sh_wr_cycles: got %h want 0006", wr_m); end
        n_cmp++; if ({a_log[1], d_log[1]} !== {32'h200, 8'h34}) begin n_fail++; $display("FAIL sh_byte0: got a=%h d=%h want 200 34", a_log[1], d_log[1]); end
        n_cmp++; if ({a_log[2], d_log[2]} !== {32'h201, 8'h12}) begin n_fail++; $display("FAIL sh_byte1: got a=%h d=%h want 201 12", a_log[2], d_log[2]); end
        n_cmp++; if ({mem[12'h200], mem[12'h201]} !== 16'h3412) begin n_fail++; $display("FAIL sh_memory: got %h%h want 3412", mem[12'h200], mem[12'h201]); end
        n_cmp++; if (vcyc !== 3) begin n_fail++; $display("FAIL sh_valid_cycle: got %0d want 3", vcyc); end
        n_cmp++; if ({vwreg, vdata} !== 33'd0) begin n_fail++; $display("FAIL sh_wb: got wreg=%b data=%h want 0 0", vwreg, vdata); end
        n_cmp++; if (stall_m !== 16'h0007) begin n_fail++; $display("FAIL sh_stall: got %h want 0007", stall_m); end
    endtask

    task automatic test_grant_gap;
        run_op(C_LOAD, 3'b010, 32'h100, 32'h0, 5'd5, 1'b1, 2, -1, -1);
        n_cmp++; if (a_log[3] !== 32'h101 || req_m[3] !== 1'b1) begin n_fail++; $display("FAIL gap_reissue: got a=%h req=%b want 101 1", a_log[3], req_m[3]); end
        n_cmp++; if (vcyc !== 7) begin n_fail++; $display("FAIL gap_valid_cycle: got %0d want 7", vcyc); end
        n_cmp++; if (vdata !== 32'h44332211) begin n_fail++; $display("FAIL gap_data: got %h want 44332211", vdata); end
    endtask

    task automatic test_passthrough;
        run_op(C_ALU, 3'b000, 32'h0, 32'h5, 5'd3, 1'b1, -1, -1, -1);
        n_cmp++; if (vcyc !== 1) begin n_fail++; $display("FAIL alu_valid_cycle: got %0d want 1", vcyc); end
        n_cmp++; if ({vwreg, vwd, vdata} !== {1'b1, 5'd3, 32'h5}) begin n_fail++; $display("FAIL alu_wb: got wreg=%b wd=%0d data=%h want 1 3 5", vwreg, vwd, vdata); end
        n_cmp++; if (stall_m !== 16'h0 || req_m !== 16'h0) begin n_fail++; $display("FAIL alu_stall_req: got stall=%h req=%h want 0 0", stall_m, req_m); end
    endtask

    task automatic test_reset_mid;
        run_op(C_STORE, 3'b010, 32'h300, 32'hDEADBEEF, 5'd0, 1'b0, -1, 2, -1);
        n_cmp++; if (wr_m !== 16'h0006) begin n_fail++; $display("FAIL rstmid_wr: got %h want 0006", wr_m); end
        n_cmp++; if (vcnt !== 0) begin n_fail++; $display("FAIL rstmid_valid: got %0d pulses want 0", vcnt); end
        run_op(C_LOAD, 3'b010, 32'h100, 32'h0, 5'd8, 1'b1, -1, -1, -1);
        n_cmp++; if (vcyc !== 6 || vdata !== 32'h44332211) begin n_fail++; $display("FAIL rstmid_next_lw: got cyc=%0d data=%h want 6 44332211", vcyc, vdata); end
    endtask

    task automatic test_rdy_hold;
        run_op(C_LOAD, 3'b000, 32'h110, 32'h0, 5'd4, 1'b1, -1, -1, 1);
        n_cmp++; if (req_m !== 16'h0004) begin n_fail++; $display("FAIL rdy_req: got %h want 0004", req_m); end
        n_cmp++; if (vcyc !== 4 || vdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL rdy_result: got cyc=%0d data=%h want 4 ffffff80", vcyc, vdata); end
    endtask

    task automatic test_misalign;
        run_op(C_LOAD, 3'b010, 32'h102, 32'h0, 5'd2, 1'b1, -1, -1, -1);
`ifdef MEM_MISALIGN_CHK_EN
        n_cmp++; if (vcyc !== 1 || verr !== 1'b1) begin n_fail++; $display("FAIL mis_err: got cyc=%0d err=%b want 1 1", vcyc, verr); end
        n_cmp++; if ({vwreg, vdata} !== 33'd0 || req_m !== 16'h0) begin n_fail++; $display("FAIL mis_quiet: got wreg=%b data=%h req=%h want 0 0 0", vwreg, vdata, req_m); end
`else
        n_cmp++; if (vcyc !== 6 || verr !== 1'b0) begin n_fail++; $display("FAIL mis_lw: got cyc=%0d err=%b want 6 0", vcyc, verr); end
        n_cmp++; if (vdata !== 32'h66554433) begin n_fail++; $display("FAIL mis_data: got %h want 66554433", vdata); end
        run_op(C_LOAD, 3'b010, 32'hFFFFFFFF, 32'h0, 5'd2, 1'b1, -1, -1, -1);
        n_cmp++; if (a_log[2] !== 32'h0 || a_log[4] !== 32'h2) begin n_fail++; $display("FAIL wrap_addr: got %h %h want 0 2", a_log[2], a_log[4]); end
        n_cmp++; if (vcyc !== 6 || vdata !== 32'h030201A5) begin n_fail++; $display("FAIL wrap_data: got cyc=%0d data=%h want 6 030201a5", vcyc, vdata); end
`endif
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        test_reset();
        test_lw();
        test_narrow_loads();
        test_store_half();
        test_grant_gap();
        test_passthrough();
        test_reset_mid();
        test_rdy_hold();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
